coherence_unit: RTL and testbench

COHERENCE_UNIT -- requirements
Module: coherence_unit

---
 rtl/coherence_unit.sv | 177 +++++++++++++++++
 tb/tb_coherence_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_unit.sv
`default_nettype none
// ============================================================================
// Module      : coherence_unit
// Description : Two-core snooping coherence controller; serialises L1 misses,
//               write-backs and upgrades through probe and memory phases.
// Revision    : 1.0 - initial release
// ============================================================================
module coherence_unit #(
    parameter int XLEN   = 32,
    parameter int CLSIZE = 128
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          L1_CU_strobe_i,
    input  logic [2*XLEN-1:0]   L1_CU_addr_i,
    input  logic [1:0]          L1_CU_rw_i,
    input  logic [1:0]          L1_CU_replacement_i,
    input  logic [1:0]          L1_CU_share_modify_i,
    input  logic [2*CLSIZE-1:0] L1_CU_data_i,
    input  logic [1:0]          L1_CU_response_ready_i,
    output logic [1:0]          CU_L1_probe_strobe_o,
    output logic [XLEN-1:0]     CU_L1_probe_addr_o,
    output logic                CU_L1_invalidate_o,
    output logic [CLSIZE-1:0]   CU_L1_data_o,
    output logic                CU_L1_make_exclusive_o,
    output logic [1:0]          CU_L1_response_ready_o,
    output logic                mem_strobe_o,
    output logic                mem_rw_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [CLSIZE-1:0]   mem_data_o,
    input  logic [CLSIZE-1:0]   mem_data_i,
    input  logic                mem_done_i
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PROBE      = 3'd1,
        WAIT_PROBE = 3'd2,
        MEM_WR     = 3'd3,
        MEM_RD     = 3'd4,
        RESP       = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_last;
    logic                r_g;
    logic [XLEN-1:0]     r_addr;
    logic                r_rfo;
    logic                r_upg;
    logic [CLSIZE-1:0]   r_line;
    logic [1:0]          r_probe_strobe;
    logic                r_invalidate;
    logic                r_make_excl;
    logic [1:0]          r_resp;
    logic                r_mem_strobe;
    logic                r_mem_rw;

    logic                w_grant;
    logic [XLEN-1:0]     w_req_addr;
    logic [CLSIZE-1:0]   w_req_data;
    logic                w_req_repl;
    logic                w_req_sm;
    logic                w_req_rw;
    logic                w_req_upg;
    logic                w_req_rfo;
    logic                w_reply;
    logic                w_reply_dirty;
    logic [CLSIZE-1:0]   w_reply_data;
    logic [1:0]          w_resp_onehot;

    // On a tie the core that did not win last time is granted.
    assign w_grant    = (&L1_CU_strobe_i) ? ~r_last : L1_CU_strobe_i[1];
    assign w_req_addr = w_grant ? L1_CU_addr_i[2*XLEN-1:XLEN] : L1_CU_addr_i[XLEN-1:0];
    assign w_req_data = w_grant ? L1_CU_data_i[2*CLSIZE-1:CLSIZE] : L1_CU_data_i[CLSIZE-1:0];
    assign w_req_repl = w_grant ? L1_CU_replacement_i[1]  : L1_CU_replacement_i[0];
    assign w_req_sm   = w_grant ? L1_CU_share_modify_i[1] : L1_CU_share_modify_i[0];
    assign w_req_rw   = w_grant ? L1_CU_rw_i[1]           : L1_CU_rw_i[0];
    assign w_req_upg  = ~w_req_repl & w_req_sm;
    assign w_req_rfo  = ~w_req_repl & ~w_req_sm & w_req_rw;

    // The probed core is always the one opposite the requester.
    assign w_reply       = r_g ? L1_CU_response_ready_i[0] : L1_CU_response_ready_i[1];
    assign w_reply_dirty = r_g ? L1_CU_share_modify_i[0]   : L1_CU_share_modify_i[1];
    assign w_reply_data  = r_g ? L1_CU_data_i[CLSIZE-1:0]  : L1_CU_data_i[2*CLSIZE-1:CLSIZE];
    assign w_resp_onehot = r_g ? 2'b10 : 2'b01;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= IDLE;
            r_last         <= 1'b1;
            r_g            <= 1'b0;
            r_addr         <= '0;
            r_rfo          <= 1'b0;
            r_upg          <= 1'b0;
            r_line         <= '0;
            r_probe_strobe <= 2'b00;
            r_invalidate   <= 1'b0;
            r_make_excl    <= 1'b0;
            r_resp         <= 2'b00;
            r_mem_strobe   <= 1'b0;
            r_mem_rw       <= 1'b0;
        end else begin
            r_probe_strobe <= 2'b00;
            r_invalidate   <= 1'b0;
            r_make_excl    <= 1'b0;
            r_resp         <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (|L1_CU_strobe_i) begin
                        r_g    <= w_grant;
                        r_last <= w_grant;
                        r_addr <= w_req_addr;
                        r_line <= w_req_data;
                        r_rfo  <= w_req_rfo;
                        r_upg  <= w_req_upg;
                        if (w_req_repl) begin
                            r_state      <= MEM_WR;
                            r_mem_strobe <= 1'b1;
                            r_mem_rw     <= 1'b1;
                        end else begin
                            r_state        <= PROBE;
                            r_probe_strobe <= w_grant ? 2'b01 : 2'b10;
                            r_invalidate   <= w_req_rfo | w_req_upg;
                        end
                    end
                end
                PROBE: r_state <= WAIT_PROBE;
                WAIT_PROBE: begin
                    if (w_reply) begin
                        r_line <= w_reply_data;
                        if (r_upg || (w_reply_dirty && r_rfo)) begin
                            r_state     <= RESP;
                            r_resp      <= w_resp_onehot;
                            r_make_excl <= 1'b1;
                        end else if (w_reply_dirty) begin
                            // Dirty data supplied to a reader must reach memory first.
                            r_state      <= MEM_WR;
                            r_mem_strobe <= 1'b1;
                            r_mem_rw     <= 1'b1;
                        end else begin
                            r_state      <= MEM_RD;
                            r_mem_strobe <= 1'b1;
                            r_mem_rw     <= 1'b0;
                        end
                    end
                end
                MEM_WR, MEM_RD: begin
                    if (mem_done_i) begin
                        if (r_state == MEM_RD) begin
                            r_line <= mem_data_i;
                        end
                        r_mem_strobe <= 1'b0;
                        r_mem_rw     <= 1'b0;
                        r_state      <= RESP;
                        r_resp       <= w_resp_onehot;
                        r_make_excl  <= r_rfo | r_upg;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign CU_L1_probe_strobe_o   = r_probe_strobe;
    assign CU_L1_probe_addr_o     = r_addr;
    assign CU_L1_invalidate_o     = r_invalidate;
    assign CU_L1_data_o           = r_line;
    assign CU_L1_make_exclusive_o = r_make_excl;
    assign CU_L1_response_ready_o = r_resp;
    assign mem_strobe_o           = r_mem_strobe;
    assign mem_rw_o               = r_mem_rw;
    assign mem_addr_o             = r_addr;
    assign mem_data_o             = r_line;

endmodule
`default_nettype wire

// File: tb/tb_coherence_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_coherence_unit
// Description : Scoreboard bench for coherence_unit; the stimulus acts as both
//               cores and memory, a monitor checks every probe/memory/response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coherence_unit;

    localparam int XLEN   = 32;
    localparam int CLSIZE = 128;

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b1;
    logic [1:0]          L1_CU_strobe_i = '0;
    logic [2*XLEN-1:0]   L1_CU_addr_i = '0;
    logic [1:0]          L1_CU_rw_i = '0;
    logic [1:0]          L1_CU_replacement_i = '0;
    logic [1:0]          L1_CU_share_modify_i = '0;
    logic [2*CLSIZE-1:0] L1_CU_data_i = '0;
    logic [1:0]          L1_CU_response_ready_i = '0;
    logic [1:0]          CU_L1_probe_strobe_o;
    logic [XLEN-1:0]     CU_L1_probe_addr_o;
    logic                CU_L1_invalidate_o;
    logic [CLSIZE-1:0]   CU_L1_data_o;
    logic                CU_L1_make_exclusive_o;
    logic [1:0]          CU_L1_response_ready_o;
    logic                mem_strobe_o;
    logic                mem_rw_o;
    logic [XLEN-1:0]     mem_addr_o;
    logic [CLSIZE-1:0]   mem_data_o;
    logic [CLSIZE-1:0]   mem_data_i = '0;
    logic                mem_done_i = 1'b0;

    coherence_unit #(.XLEN(XLEN), .CLSIZE(CLSIZE)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .L1_CU_strobe_i         (L1_CU_strobe_i),
        .L1_CU_addr_i           (L1_CU_addr_i),
        .L1_CU_rw_i             (L1_CU_rw_i),
        .L1_CU_replacement_i    (L1_CU_replacement_i),
        .L1_CU_share_modify_i   (L1_CU_share_modify_i),
        .L1_CU_data_i           (L1_CU_data_i),
        .L1_CU_response_ready_i (L1_CU_response_ready_i),
        .CU_L1_probe_strobe_o   (CU_L1_probe_strobe_o),
        .CU_L1_probe_addr_o     (CU_L1_probe_addr_o),
        .CU_L1_invalidate_o     (CU_L1_invalidate_o),
        .CU_L1_data_o           (CU_L1_data_o),
        .CU_L1_make_exclusive_o (CU_L1_make_exclusive_o),
        .CU_L1_response_ready_o (CU_L1_response_ready_o),
        .mem_strobe_o           (mem_strobe_o),
        .mem_rw_o               (mem_rw_o),
        .mem_addr_o             (mem_addr_o),
        .mem_data_o             (mem_data_o),
        .mem_data_i             (mem_data_i),
        .mem_done_i             (mem_done_i)
    );

    always #5 clk_i = ~clk_i;

    // kind: 0 = probe (core = target), 1 = memory request, 2 = response
    typedef struct {
        int                kind;
        int                core;
        logic [XLEN-1:0]   addr;
        logic [CLSIZE-1:0] data;
        logic              flag;
        logic              chk_data;
        int                delta;
    } ev_t;

    ev_t                 sb[$];
    ev_t                 cur_mem;
    int                  total = 0;
    int                  bad = 0;
    int                  cyc = 0;
    int                  last_cyc = 0;

    logic [1:0]          req_sm = '0;
    logic [2*CLSIZE-1:0] req_data = '0;
    logic                silent = 1'b0;
    logic                rep_dirty = 1'b0;
    logic [CLSIZE-1:0]   rep_data = '0;
    int                  pdelay = 0;
    int                  mdelay = 0;
    int                  pcnt = 0;
    int                  ptgt = 0;
    int                  mcnt = 0;
    logic                mem_busy = 1'b0;

    task automatic chk(input string name, input logic [CLSIZE-1:0] act, input logic [CLSIZE-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int idx(input logic [1:0] v);
        return (v == 2'b01) ? 0 : ((v == 2'b10) ? 1 : 2);
    endfunction

    task automatic push(input int kind, input int core, input logic [XLEN-1:0] addr,
                        input logic [CLSIZE-1:0] data, input logic flag, input logic chkd, input int delta);
        ev_t e;
        e.kind = kind; e.core = core; e.addr = addr; e.data = data;
        e.flag = flag; e.chk_data = chkd; e.delta = delta;
        sb.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int core, input logic [XLEN-1:0] addr,
                            input logic [CLSIZE-1:0] data, input logic flag);
        ev_t   e;
        string nm;
        nm = (kind == 0) ? "probe" : ((kind == 1) ? "mem" : "resp");
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: actual=core%0d addr=%0h required=no event", nm, core, addr);
            return;
        end
        e = sb.pop_front();
        chk({nm, "_kind"}, CLSIZE'(kind), CLSIZE'(e.kind));
        if (kind != 1) chk({nm, "_core"}, CLSIZE'(core), CLSIZE'(e.core));
        if (kind != 2) chk({nm, "_addr"}, CLSIZE'(addr), CLSIZE'(e.addr));
        chk({nm, "_flag"}, CLSIZE'(flag), CLSIZE'(e.flag));
        if (e.chk_data) chk({nm, "_data"}, data, e.data);
        if (e.delta >= 0) chk({nm, "_latency"}, CLSIZE'(cyc - last_cyc), CLSIZE'(e.delta));
        last_cyc = cyc;
        if (kind == 1) cur_mem = e;
    endtask

    // Monitor: compares every DUT output event against the scoreboard head.
    initial begin : monitor
        logic mp;
        mp = 1'b0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (rst_i) begin
                mp = 1'b0;
            end else begin
                if (CU_L1_probe_strobe_o != 2'b00)
                    check_ev(0, idx(CU_L1_probe_strobe_o), CU_L1_probe_addr_o, '0, CU_L1_invalidate_o);
                if (mem_strobe_o && !mp) begin
                    check_ev(1, 0, mem_addr_o, mem_data_o, mem_rw_o);
                end else if (mem_strobe_o) begin
                    chk("mem_hold_addr", CLSIZE'(mem_addr_o), CLSIZE'(cur_mem.addr));
                    chk("mem_hold_rw", CLSIZE'(mem_rw_o), CLSIZE'(cur_mem.flag));
                    if (cur_mem.chk_data) chk("mem_hold_data", mem_data_o, cur_mem.data);
                end
                if (CU_L1_response_ready_o != 2'b00)
                    check_ev(2, idx(CU_L1_response_ready_o), '0, CU_L1_data_o, CU_L1_make_exclusive_o);
                mp = mem_strobe_o;
            end
        end
    end

    task automatic issue(input int k, input logic [XLEN-1:0] a, input logic rw, input logic repl,
                         input logic sm, input logic [CLSIZE-1:0] d);
        L1_CU_addr_i[k*XLEN +: XLEN] = a;
        L1_CU_rw_i[k]                = rw;
        L1_CU_replacement_i[k]       = repl;
        req_sm[k]                    = sm;
        req_data[k*CLSIZE +: CLSIZE] = d;
        L1_CU_share_modify_i         = req_sm;
        L1_CU_data_i                 = req_data;
        L1_CU_strobe_i[k]            = 1'b1;
    endtask

    // One negedge of core and memory behaviour.
    task automatic step();
        @(negedge clk_i);
        L1_CU_response_ready_i = 2'b00;
        mem_done_i             = 1'b0;
        L1_CU_share_modify_i   = req_sm;
        L1_CU_data_i           = req_data;
        for (int k = 0; k < 2; k++)
            if (CU_L1_response_ready_o[k]) L1_CU_strobe_i[k] = 1'b0;
        if (pcnt > 0) begin
            pcnt--;
            if (pcnt == 0) begin
                L1_CU_response_ready_i[ptgt]         = 1'b1;
                L1_CU_share_modify_i[ptgt]           = rep_dirty;
                L1_CU_data_i[ptgt*CLSIZE +: CLSIZE]  = rep_data;
            end
        end
        if (CU_L1_probe_strobe_o != 2'b00 && !silent) begin
            ptgt = CU_L1_probe_strobe_o[1] ? 1 : 0;
            pcnt = pdelay + 1;
        end
        if (!mem_strobe_o) begin
            mem_busy = 1'b0;
        end else if (!mem_busy) begin
            mem_busy = 1'b1;
            mcnt     = mdelay;
            if (mcnt == 0) mem_done_i = 1'b1;
        end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) mem_done_i = 1'b1;
        end
    endtask

    task automatic run(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((L1_CU_strobe_i != 2'b00 || sb.size() != 0) && n < budget);
        if (L1_CU_strobe_i != 2'b00 || sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: actual=%0d events pending, strobes=%b required=0 pending", sb.size(), L1_CU_strobe_i);
            L1_CU_strobe_i = 2'b00;
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, CLSIZE'({CU_L1_probe_strobe_o, CU_L1_invalidate_o, CU_L1_make_exclusive_o,
                                     CU_L1_response_ready_o, mem_strobe_o, mem_rw_o}), '0);
        chk({tag, "_addr"}, CLSIZE'({CU_L1_probe_addr_o, mem_addr_o}), '0);
        chk({tag, "_l1_data"}, CU_L1_data_o, '0);
        chk({tag, "_mem_data"}, mem_data_o, '0);
    endtask

    initial begin : stimulus
        logic [CLSIZE-1:0] d1;
        logic [CLSIZE-1:0] d2;
        logic [CLSIZE-1:0] a5;
        int                n;
        d1 = {4{32'h1111_0100}};
        d2 = {4{32'h2222_0100}};
        a5 = {16{8'hA5}};

        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        // Simultaneous reads of 0x100: core 0 first, then core 1, twice.
        pdelay = 0; mdelay = 1; rep_dirty = 1'b0; rep_data = '0;
        mem_data_i = d1;
        push(0, 1, 32'h100, '0, 1'b0, 1'b0, -1);
        push(1, 0, 32'h100, '0, 1'b0, 1'b0, 2);
        push(2, 0, '0, d1, 1'b0, 1'b1, 2);
        push(0, 0, 32'h100, '0, 1'b0, 1'b0, -1);
        push(1, 0, 32'h100, '0, 1'b0, 1'b0, 2);
        push(2, 1, '0, d1, 1'b0, 1'b1, 2);
        issue(0, 32'h100, 1'b0, 1'b0, 1'b0, '0);
        issue(1, 32'h100, 1'b0, 1'b0, 1'b0, '0);
        run(200);
        mem_data_i = d2;
        push(0, 1, 32'h100, '0, 1'b0, 1'b0, -1);
        push(1, 0, 32'h100, '0, 1'b0, 1'b0, 2);
        push(2, 0, '0, d2, 1'b0, 1'b1, 2);
        push(0, 0, 32'h100, '0, 1'b0, 1'b0, -1);
        push(1, 0, 32'h100, '0, 1'b0, 1'b0, 2);
        push(2, 1, '0, d2, 1'b0, 1'b1, 2);
        issue(0, 32'h100, 1'b0, 1'b0, 1'b0, '0);
        issue(1, 32'h100, 1'b0, 1'b0, 1'b0, '0);
        run(200);

        // Write-back of 0x200 (replacement outranks share_modify and rw).
        mdelay = 3;
        push(1, 0, 32'h200, a5, 1'b1, 1'b1, -1);
        push(2, 0, '0, '0, 1'b0, 1'b0, 4);
        issue(0, 32'h200, 1'b1, 1'b1, 1'b1, a5);
        run(100);

        // Core 1 read of 0x300, core 0 supplies dirty 0x1234.
        mdelay = 0; rep_dirty = 1'b1; rep_data = 128'h1234;
        push(0, 0, 32'h300, '0, 1'b0, 1'b0, -1);
        push(1, 0, 32'h300, 128'h1234, 1'b1, 1'b1, 2);
        push(2, 1, '0, 128'h1234, 1'b0, 1'b1, 1);
        issue(1, 32'h300, 1'b0, 1'b0, 1'b0, '0);
        run(100);

        // Core 0 upgrade of 0x400 (share_modify outranks rw), no memory access.
        pdelay = 1; rep_dirty = 1'b0; rep_data = '0;
        push(0, 1, 32'h400, '0, 1'b1, 1'b0, -1);
        push(2, 0, '0, '0, 1'b1, 1'b0, 3);
        issue(0, 32'h400, 1'b1, 1'b0, 1'b1, '0);
        run(100);

        // Core 1 RFO of 0x500, clean reply, memory returns 0xBEEF.
        pdelay = 0; mdelay = 2; mem_data_i = 128'hBEEF;
        push(0, 0, 32'h500, '0, 1'b1, 1'b0, -1);
        push(1, 0, 32'h500, '0, 1'b0, 1'b0, 2);
        push(2, 1, '0, 128'hBEEF, 1'b1, 1'b1, 3);
        issue(1, 32'h500, 1'b1, 1'b0, 1'b0, '0);
        run(100);

        // Core 0 RFO of 0x600, core 1 supplies dirty 0x77 directly.
        rep_dirty = 1'b1; rep_data = 128'h77;
        push(0, 1, 32'h600, '0, 1'b1, 1'b0, -1);
        push(2, 0, '0, 128'h77, 1'b1, 1'b1, 2);
        issue(0, 32'h600, 1'b1, 1'b0, 1'b0, '0);
        run(100);

        // Reset while waiting for a probe reply that never comes.
        silent = 1'b1; rep_dirty = 1'b0; rep_data = '0;
        push(0, 1, 32'h700, '0, 1'b0, 1'b0, -1);
        issue(0, 32'h700, 1'b0, 1'b0, 1'b0, 128'h99);
        n = 0;
        while (CU_L1_probe_strobe_o == 2'b00 && n < 20) begin
            step();
            n++;
        end
        chk("probe_before_reset", CLSIZE'(CU_L1_probe_strobe_o), CLSIZE'(2'b10));
        step();
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midreset");
        L1_CU_strobe_i = 2'b00;
        req_sm = '0;
        req_data = '0;
        silent = 1'b0;
        pcnt = 0;
        mem_busy = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        chk("sb_empty_after_reset", CLSIZE'(sb.size()), '0);

        // Normal transaction after the abandoned one.
        mdelay = 0; mem_data_i = 128'hC0DE;
        push(0, 0, 32'h800, '0, 1'b0, 1'b0, -1);
        push(1, 0, 32'h800, '0, 1'b0, 1'b0, 2);
        push(2, 1, '0, 128'hC0DE, 1'b0, 1'b1, 1);
        issue(1, 32'h800, 1'b0, 1'b0, 1'b0, '0);
        run(100);

        repeat (3) step();
        chk("sb_empty_at_end", CLSIZE'(sb.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
